// File: rtl/seq_detect.sv
// Run-length detector: flags RUN_LEN equal serial bits, counts match events.
// Optional hit counter built only when SEQ_DETECT_HIT_CNT_EN is defined.
module seq_detect #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             w,
    input  logic             en,
    output logic             z,
    output logic [3:0]       run,
    output logic             last,
    output logic [CNT_W-1:0] hits
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2
    } state_t;

    localparam logic [3:0] L_MAX = 4'(RUN_LEN);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_run;
    logic [3:0] w_run_nxt;
    logic [3:0] w_run_inc;
    logic       r_last;

    // State, run length and last bit advance only on enabled edges
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state <= IDLE;
            r_run   <= 4'd0;
            r_last  <= 1'b0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_last  <= w;
        end
    end

    assign w_run_inc = (r_run >= L_MAX) ? L_MAX : r_run + 4'd1;

    // Next state: extend a matching run, restart at 1 on a polarity change
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = w ? RUN1 : RUN0;
                w_run_nxt   = 4'd1;
            end
            RUN0: begin
                if (!w) begin
                    w_run_nxt = w_run_inc;
                end else begin
                    w_state_nxt = RUN1;
                    w_run_nxt   = 4'd1;
                end
            end
            RUN1: begin
                if (w) begin
                    w_run_nxt = w_run_inc;
                end else begin
                    w_state_nxt = RUN0;
                    w_run_nxt   = 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_run_nxt   = 4'd0;
            end
        endcase
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        z    = ((r_state == RUN0) || (r_state == RUN1)) &&
               (r_run == L_MAX);
        run  = r_run;
        last = r_last;
    end

`ifdef SEQ_DETECT_HIT_CNT_EN
    logic             w_hit;
    logic [CNT_W-1:0] r_hits;

    assign w_hit = en && (r_state != IDLE) &&
                   (r_run == L_MAX - 4'd1) &&
                   (w_run_nxt == L_MAX);

    // Saturating count of run-reaches-RUN_LEN events
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_hits <= '0;
        end else if (w_hit && (r_hits != {CNT_W{1'b1}})) begin
            r_hits <= r_hits + 1'b1;
        end
    end

    assign hits = r_hits;
`else
    assign hits = '0;
`endif

endmodule

// File: tb/tb_seq_detect.sv
// Scoreboard bench for seq_detect: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream; a reference model predicts every output.
module tb_seq_detect;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
    logic       w   = 1'b0;
    logic       en  = 1'b0;
    logic       z_a, last_a, z_b, last_b;
    logic [3:0] run_a, run_b;
    logic [7:0] hits_a;
    logic [1:0] hits_b;

`ifdef SEQ_DETECT_HIT_CNT_EN
    localparam bit HC = 1'b1;
`else
    localparam bit HC = 1'b0;
`endif

    seq_detect #(.RUN_LEN(4), .CNT_W(8)) u_dut_a (
        .clk (clk), .r (r), .w (w), .en (en),
        .z (z_a), .run (run_a), .last (last_a), .hits (hits_a)
    );

    seq_detect #(.RUN_LEN(4), .CNT_W(2)) u_dut_b (
        .clk (clk), .r (r), .w (w), .en (en),
        .z (z_b), .run (run_b), .last (last_b), .hits (hits_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int z;
        int run;
        int last;
        int ha;
        int hb;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model: m_st 0=no sample, 1=zeros, 2=ones
    int m_st, m_run, m_last, m_ha, m_hb;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_run = 0; m_last = 0; m_ha = 0; m_hb = 0;
    endfunction

    function automatic void model_step(input bit wi, input bit ei);
        int prev;
        if (!ei) return;
        prev = m_run;
        if (m_st == 0 || (m_st == 2) != wi) begin
            m_st  = wi ? 2 : 1;
            m_run = 1;
        end else if (m_run < 4) begin
            m_run = m_run + 1;
        end
        if (prev == 3 && m_run == 4) begin
            if (m_ha < 255) m_ha++;
            if (m_hb < 3) m_hb++;
        end
        m_last = wi;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.z    = (m_st != 0 && m_run == 4) ? 1 : 0;
        e.run  = m_run;
        e.last = m_last;
        e.ha   = HC ? m_ha : 0;
        e.hb   = HC ? m_hb : 0;
        sb_q.push_back(e);
    endfunction

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, ".empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".z"},     32'(z_a),    32'(e.z));
        chk({tag, ".run"},   32'(run_a),  32'(e.run));
        chk({tag, ".last"},  32'(last_a), 32'(e.last));
        chk({tag, ".hits"},  32'(hits_a), 32'(e.ha));
        chk({tag, ".z2"},    32'(z_b),    32'(e.z));
        chk({tag, ".run2"},  32'(run_b),  32'(e.run));
        chk({tag, ".hits2"}, 32'(hits_b), 32'(e.hb));
    endtask

    task automatic step(input string tag, input bit wi, input bit ei);
        @(negedge clk);
        w  = wi;
        en = ei;
        model_step(wi, ei);
        push_exp();
        @(posedge clk);
        #1;
        pop_cmp(tag);
    endtask

    // assert reset between edges, check at once, release on a negedge
    task automatic async_reset(input string tag);
        #2;
        r  = 1'b0;
        en = 1'b0;
        model_reset();
        push_exp();
        #1;
        pop_cmp(tag);
        chk({tag, ".z_now"},   32'(z_a),   32'd0);
        chk({tag, ".run_now"}, 32'(run_a), 32'd0);
        @(negedge clk);
        r = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        push_exp();
        pop_cmp("rst");
        chk("rst.hits", 32'(hits_a), 32'd0);
        @(negedge clk);
        r = 1'b1;

        for (int i = 1; i <= 4; i++) step("ones4", 1'b1, 1'b1);
        chk("tp1.z", 32'(z_a), 32'd1);
        chk("tp1.run", 32'(run_a), 32'd4);
        chk("tp1.hits", 32'(hits_a), HC ? 32'd1 : 32'd0);

        for (int i = 0; i < 3; i++) step("sust1", 1'b1, 1'b1);
        chk("tp2.hits", 32'(hits_a), HC ? 32'd1 : 32'd0);
        step("flip0", 1'b0, 1'b1);
        chk("tp2.z", 32'(z_a), 32'd0);
        chk("tp2.run", 32'(run_a), 32'd1);

        for (int i = 0; i < 3; i++) step("zeros", 1'b0, 1'b1);
        chk("tp3.z", 32'(z_a), 32'd1);
        chk("tp3.hits", 32'(hits_a), HC ? 32'd2 : 32'd0);

        for (int i = 0; i < 5; i++) step("hold", 1'(i[0] ^ 1), 1'b0);
        chk("tp3.hold_run", 32'(run_a), 32'd4);

        for (int i = 0; i < 10; i++) begin
            step("alt", 1'(~i[0]), 1'b1);
            chk("alt.z", 32'(z_a), 32'd0);
        end

        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b1);
        chk("tp5.run3", 32'(run_a), 32'd3);
        async_reset("midrst");
        for (int i = 0; i < 3; i++) step("post_rst", 1'b1, 1'b1);
        chk("tp5.z3", 32'(z_a), 32'd0);
        step("post_rst4", 1'b1, 1'b1);
        chk("tp5.z4", 32'(z_a), 32'd1);

        @(posedge clk);
        async_reset("rst2");
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 4; i++) step("sat", 1'(m[0]), 1'b1);
            chk("sat.hits2", 32'(hits_b),
                HC ? 32'((m < 3) ? m + 1 : 3) : 32'd0);
            chk("sat.hits", 32'(hits_a), HC ? 32'(m + 1) : 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect.md
# seq_detect

Serial run-length sequence detector that consumes the bit stream produced by the 4-stage D flip-flop shift chain on the DE1 board. It watches the serial bit presented on each enabled clock edge and asserts `z` while the most recent `RUN_LEN` sampled bits are all equal, either all 0 or all 1. It also exposes the current run length, the last sampled bit and a detection counter so they can be driven onto LEDs.

## Interface
- `RUN_LEN`, default 4: number of consecutive equal bits required for a match; legal range 2..15.
- `CNT_W`, default 8: width of the detection counter `hits`; legal range 1..16.

- `clk`  in  1: system clock, rising edge.
- `r`  in  1: reset, asynchronous, active-low.
- `w`  in  1: serial data bit, i.e. the output of the shift chain.
- `en`  in  1: sample enable; `w` is consumed only on edges where `en`=1. Tie high for every-clock operation.
- `z`  out  1: match flag, registered Moore output.
- `run`  out  4: current run length, saturating at `RUN_LEN`.
- `last`  out  1: value of the most recently sampled bit.
- `hits`  out  CNT_W: number of match events, saturating.

## Operation
- FSM states:
  - IDLE: no bit sampled since reset.
  - RUN0: current run is made of 0s.
  - RUN1: current run is made of 1s.
- Transitions happen only on edges with `en`=1. With `en`=0, all state and outputs hold.
- From IDLE:
  - `w`=0 → RUN0, `run`=1.
  - `w`=1 → RUN1, `run`=1.
- From RUNx:
  - `w` equals the run value → stay, `run` = min(`run`+1, `RUN_LEN`).
  - `w` differs → switch to the other RUN state, `run`=1.
- `last` ← `w` on every enabled edge.
- `z` = 1 exactly when state is RUN0 or RUN1 and `run` == `RUN_LEN`. It is decoded from registered state only, with no combinational path from `w`.
- A match event occurs on an enabled edge where `run` goes from `RUN_LEN`-1 to `RUN_LEN`. `hits` increments by 1 on that edge.
- `hits` saturates at 2^CNT_W−1 and never wraps.
- A sustained run produces one event only.
- A run that breaks and then reaches `RUN_LEN` again produces a new event.
- A polarity flip directly from a full run restarts at `run`=1. A new match needs `RUN_LEN` more equal bits.

## Timing
- Latency: `w` sampled at enabled edge k is reflected in `run`/`last`/`z`/`hits` immediately after edge k.
- `z` rises after the `RUN_LEN`-th consecutive equal sample. It falls after the first differing sample.
- Reset (`r`=0) is asynchronous and takes effect without any clock edge. State becomes IDLE, `run`=0, `last`=0, `z`=0, `hits`=0.
- Reset mid-run discards all history. After `r` returns high, a full `RUN_LEN` samples are needed for a new match.
- `r` deassertion is synchronous to `clk` by system convention. The first enabled edge after release is processed normally.
- `en` and `w` are sampled together on the same edge. No other handshake exists.

## Configuration
- `SEQ_DETECT_HIT_CNT_EN`:
  - Defined: the `hits` counter and its saturation logic are built as described.
  - Undefined: no counter flops are built, `hits` is tied to 0, and `z`/`run`/`last` behaviour is unchanged.

## Test plan
- Reset, then `w`=1 with `en`=1 for 4 edges (RUN_LEN=4) → `z`=0 after edges 1–3; after edge 4: `z`=1, `run`=4, `last`=1, `hits`=1.
- Continue `w`=1 for 3 edges, then `w`=0 for 1 edge → `z` stays 1 and `hits` stays 1 through the 1s; after the 0: `z`=0, `run`=1, `last`=0.
- Then `w`=0 for 3 more edges → `z`=1, `run`=4, `hits`=2; toggle `w` for 5 edges with `en`=0 → no output changes.
- Alternating `w`=1,0,1,0… for 10 enabled edges → `z` never 1, `run`=1 after every edge, `hits` unchanged.
- At `run`=3 of a 1-run, drive `r`=0 between clock edges → immediately `z`=0, `run`=0, `hits`=0, `last`=0; after release, 3 ones give `z`=0 and the 4th gives `z`=1.
- With CNT_W=2, produce 5 separate 0000/1111 matches → `hits` goes 1, 2, 3, 3, 3. Rebuild without `SEQ_DETECT_HIT_CNT_EN` → `hits`=0 throughout and `z` matches the first build.
